// File: rtl/des_top.sv
// des_top: iterative single-DES engine, one Feistel round per clock.
// Every internal vector is indexed so that vector bit [n-1] holds DES bit n.
// Port bit [0] is DES bit 1, so each table entry T maps directly to
// out[j-1] = in[T[j]-1] and no bit reversal is needed anywhere.
// Encrypt and decrypt share one round datapath. Only the direction and amount
// of the C/D rotation change, so the subkeys are derived on the fly.
module des_top (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        decrypt,
   input  logic [63:0] key,
   input  logic [63:0] text_in,
   output logic [63:0] text_out,
   output logic        busy,
   output logic        done
);

   localparam int IP_TBL [64] = '{
      58, 50, 42, 34, 26, 18, 10,  2,  60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6,  64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7};

   localparam int FP_TBL [64] = '{
      40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25};

   localparam int E_TBL [48] = '{
      32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

   localparam int P_TBL [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

   // S-box contents, index = box*64 + row*16 + column
   localparam logic [3:0] SBOX_TBL [512] = '{
      // S1
      14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
      // S2
      15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
      // S3
      10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
      // S4
       7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
      // S5
       2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
      // S6
      12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
      // S7
       4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
      // S8
      13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

   typedef enum logic [1:0] {IDLE, ROUND, FINISH} state_t;

   state_t      state_reg, state_next;
   logic [4:0]  round_reg;
   logic        mode_reg;
   logic [31:0] l_reg, r_reg;
   logic [27:0] c_reg, d_reg;
   logic [63:0] text_out_reg;
   logic        done_reg;

   logic        load_en, round_en, finish_en;
   logic [63:0] ip_out, fp_in, fp_out;
   logic [55:0] pc1_out, cd_rot;
   logic [27:0] c_rot, d_rot;
   logic [47:0] e_out, k_sub, e_xor;
   logic [31:0] s_out, f_out;
   logic        short_step;
   logic        unused_parity;

   // In DES numbering a left rotate moves bit 2 into bit 1, which means a
   // shift towards index 0 here.
   function automatic logic [27:0] rol1(input logic [27:0] x);
      return {x[0], x[27:1]};
   endfunction

   function automatic logic [27:0] rol2(input logic [27:0] x);
      return {x[1:0], x[27:2]};
   endfunction

   function automatic logic [27:0] ror1(input logic [27:0] x);
      return {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] ror2(input logic [27:0] x);
      return {x[25:0], x[27:26]};
   endfunction

   // PC-1 drops the parity bits, so they are only collected here.
   assign unused_parity = ^{key[63], key[55], key[47], key[39],
                            key[31], key[23], key[15], key[7]};

   // Fixed bit permutations: IP, FP, PC-1, E, PC-2, P
   genvar gi;
   generate
      for (gi = 0; gi < 64; gi++) begin : g_ip_fp
         assign ip_out[gi] = text_in[IP_TBL[gi]-1];
         assign fp_out[gi] = fp_in[FP_TBL[gi]-1];
      end
      for (gi = 0; gi < 56; gi++) begin : g_pc1
         assign pc1_out[gi] = key[PC1_TBL[gi]-1];
      end
      for (gi = 0; gi < 48; gi++) begin : g_e_pc2
         assign e_out[gi] = r_reg[E_TBL[gi]-1];
         assign k_sub[gi] = cd_rot[PC2_TBL[gi]-1];
      end
      for (gi = 0; gi < 32; gi++) begin : g_p
         assign f_out[gi] = s_out[P_TBL[gi]-1];
      end
      // Each S-box takes b1..b6: the row is b1b6 and the column is b2..b5.
      // Its 4-bit result is placed MSB first in DES order.
      for (gi = 0; gi < 8; gi++) begin : g_sbox
         logic [8:0] sbox_idx;
         logic [3:0] sbox_val;
         assign sbox_idx = {3'(gi), e_xor[6*gi], e_xor[6*gi+5],
                            e_xor[6*gi+1], e_xor[6*gi+2],
                            e_xor[6*gi+3], e_xor[6*gi+4]};
         assign sbox_val = SBOX_TBL[sbox_idx];
         assign s_out[4*gi+3:4*gi] = {sbox_val[0], sbox_val[1],
                                      sbox_val[2], sbox_val[3]};
      end
   endgenerate

   assign e_xor  = e_out ^ k_sub;
   assign cd_rot = {d_rot, c_rot};
   // The final swap places R16 in DES bits 1..32 ahead of the inverse IP.
   assign fp_in  = {l_reg, r_reg};

   assign short_step = (round_reg == 5'd1) || (round_reg == 5'd2) ||
                       (round_reg == 5'd9) || (round_reg == 5'd16);

   // Rotate C/D for the current round. Encryption rotates left.
   // Decryption rotates right so that K16..K1 are produced in order.
   always_comb begin
      c_rot = c_reg;
      d_rot = d_reg;
      if (!mode_reg) begin
         if (short_step) begin
            c_rot = rol1(c_reg);
            d_rot = rol1(d_reg);
         end else begin
            c_rot = rol2(c_reg);
            d_rot = rol2(d_reg);
         end
      end else if (round_reg != 5'd1) begin
         if (short_step) begin
            c_rot = ror1(c_reg);
            d_rot = ror1(d_reg);
         end else begin
            c_rot = ror2(c_reg);
            d_rot = ror2(d_reg);
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // FSM next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = ROUND;
         ROUND:   if (round_reg == 5'd16) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs and datapath enables
   always_comb begin
      busy      = (state_reg != IDLE);
      load_en   = (state_reg == IDLE) && start;
      round_en  = (state_reg == ROUND);
      finish_en = (state_reg == FINISH);
   end

   // Load the block and key, then run one Feistel round per clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round_reg <= '0;
         mode_reg  <= 1'b0;
         l_reg     <= '0;
         r_reg     <= '0;
         c_reg     <= '0;
         d_reg     <= '0;
      end else if (load_en) begin
         round_reg <= 5'd1;
         mode_reg  <= decrypt;
         l_reg     <= ip_out[31:0];
         r_reg     <= ip_out[63:32];
         c_reg     <= pc1_out[27:0];
         d_reg     <= pc1_out[55:28];
      end else if (round_en) begin
         round_reg <= (round_reg == 5'd16) ? 5'd0 : round_reg + 5'd1;
         l_reg     <= r_reg;
         r_reg     <= l_reg ^ f_out;
         c_reg     <= c_rot;
         d_reg     <= d_rot;
      end
   end

   // Capture the result and raise a one-cycle completion pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         text_out_reg <= '0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= finish_en;
         if (finish_en) text_out_reg <= fp_out;
      end
   end

   assign text_out = text_out_reg;
   assign done     = done_reg;

endmodule

// File: tb/tb_des_top.sv
// tb_des_top: directed-vector bench for des_top.
// It uses known-answer vectors, a parity-bit check, a random round trip,
// and tests of the START/BUSY/DONE handshake and reset abort.
module tb_des_top;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        decrypt = 1'b0;
   logic [63:0] key = '0;
   logic [63:0] text_in = '0;
   logic [63:0] text_out;
   logic        busy;
   logic        done;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [63:0] KEY_A  = 64'h8FFB3DD99EEA2CC8;
   localparam logic [63:0] PT_A   = 64'hF7B3D591E6A2C480;
   localparam logic [63:0] CT_A   = 64'hA02D50F02AC817A1;
   localparam logic [63:0] KEY_B  = 64'h133457799BBCDFF1;
   localparam logic [63:0] PT_B   = 64'h0123456789ABCDEF;
   localparam logic [63:0] CT_B   = 64'hAC0A339F8F67C3C8;
   localparam logic [63:0] PARITY = 64'h8080808080808080;

   des_top dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .decrypt  (decrypt),
      .key      (key),
      .text_in  (text_in),
      .text_out (text_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a command; call on a falling edge.
   task automatic issue(input logic [63:0] k, input logic [63:0] t,
                        input logic dec);
      start   = 1'b1;
      key     = k;
      text_in = t;
      decrypt = dec;
   endtask

   // Follow one block to DONE. cyc counts falling edges after the command,
   // so DONE is expected on the 18th. If glitch is set, the inputs are
   // scrambled and START is pulsed again while the block is in flight.
   task automatic wait_done(input string tag, input bit glitch,
                            output logic [63:0] res, output int cyc,
                            output int busy_cnt, output bit hold_ok);
      logic [63:0] held;
      logic [63:0] k0, t0;
      logic        d0;
      held = text_out;
      k0 = key; t0 = text_in; d0 = decrypt;
      res = '0; cyc = 0; busy_cnt = 0; hold_ok = 1'b1;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (glitch) begin
            if (cyc == 2) begin
               key = ~key; text_in = ~text_in; decrypt = ~decrypt;
            end
            if (cyc == 5) start = 1'b1;
            if (cyc == 6) start = 1'b0;
         end
         if (busy) busy_cnt++;
         if (done) begin
            res = text_out;
            break;
         end else if (text_out !== held) begin
            hold_ok = 1'b0;
         end
      end
      $display("txn %-12s key=%h in=%h dec=%0d out=%h cyc=%0d busy=%0d",
               tag, k0, t0, d0, res, cyc, busy_cnt);
   endtask

   // Run one block from a falling edge and check the result and handshake.
   task automatic run_check(input string tag, input logic [63:0] k,
                            input logic [63:0] t, input logic dec,
                            input logic [63:0] exp, input bit glitch);
      logic [63:0] res;
      int cyc, bcnt;
      bit hold;
      @(negedge clk);
      issue(k, t, dec);
      wait_done(tag, glitch, res, cyc, bcnt, hold);
      check_vec({tag, " result"}, res, exp);
      check_vec({tag, " latency"}, 64'(cyc), 64'd18);
      check_vec({tag, " busy_cycles"}, 64'(bcnt), 64'd17);
      check_vec({tag, " hold"}, 64'(hold), 64'd1);
   endtask

   initial begin
      logic [63:0] res, res2, rk, rt;
      int cyc, bcnt;
      bit hold, saw_done;

      // reset state
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_vec("reset text_out", text_out, 64'd0);
      check_vec("reset busy", 64'(busy), 64'd0);
      check_vec("reset done", 64'(done), 64'd0);
      rst_n = 1'b1;

      // known-answer vectors
      run_check("enc_a", KEY_A, PT_A, 1'b0, CT_A, 1'b0);
      run_check("dec_a", KEY_A, CT_A, 1'b1, PT_A, 1'b0);
      run_check("enc_b", KEY_B, PT_B, 1'b0, CT_B, 1'b0);
      run_check("dec_b", KEY_B, CT_B, 1'b1, PT_B, 1'b0);

      // parity bits of the key must not matter
      run_check("enc_parity", KEY_A ^ PARITY, PT_A, 1'b0, CT_A, 1'b0);
      run_check("dec_parity", KEY_B ^ PARITY, CT_B, 1'b1, PT_B, 1'b0);

      // START and input changes during a block are ignored
      run_check("enc_glitch", KEY_A, PT_A, 1'b0, CT_A, 1'b1);

      // back-to-back: second START in the DONE cycle
      @(negedge clk);
      issue(KEY_A, PT_A, 1'b0);
      wait_done("b2b_first", 1'b0, res, cyc, bcnt, hold);
      check_vec("b2b first result", res, CT_A);
      issue(KEY_A, CT_A, 1'b1);
      wait_done("b2b_second", 1'b0, res2, cyc, bcnt, hold);
      check_vec("b2b second result", res2, PT_A);
      check_vec("b2b done gap", 64'(cyc), 64'd18);
      check_vec("b2b busy_cycles", 64'(bcnt), 64'd17);

      // reset during round 8 aborts the block
      @(negedge clk);
      issue(KEY_B, PT_B, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_vec("abort text_out", text_out, 64'd0);
      check_vec("abort busy", 64'(busy), 64'd0);
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check_vec("abort no_done", 64'(saw_done), 64'd0);
      check_vec("abort text_out held", text_out, 64'd0);
      run_check("enc_after_rst", KEY_B, PT_B, 1'b0, CT_B, 1'b0);

      // random round trip: decrypt(encrypt(x)) == x
      for (int i = 0; i < 100; i++) begin
         rk = {$urandom, $urandom};
         rt = {$urandom, $urandom};
         @(negedge clk);
         issue(rk, rt, 1'b0);
         wait_done("rt_enc", 1'b0, res, cyc, bcnt, hold);
         check_vec("roundtrip enc latency", 64'(cyc), 64'd18);
         @(negedge clk);
         issue(rk, res, 1'b1);
         wait_done("rt_dec", 1'b0, res2, cyc, bcnt, hold);
         check_vec("roundtrip dec result", res2, rt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
